// File: rtl/rf_access_master_pkg.sv
// Shared types and defaults for the register-file access master.
// Latency: n/a (types only).
// Backpressure: n/a.
package rf_access_master_pkg;

  // Register word width and index width of the 32x32 dual-read file.
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  // Sequencer states; encodings are fixed so monitors can decode them.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ISSUE   = 3'd1,
    ST_RD_CAPTURE = 3'd2,
    ST_WR_ISSUE   = 3'd3,
    ST_RESP       = 3'd4
  } rfm_state_t;

  // First state entered when a request is accepted. A request with neither
  // bit set is consumed in place and produces no response.
  function automatic rfm_state_t first_state(input logic rd, input logic wr);
    if (rd)      return ST_RD_ISSUE;
    else if (wr) return ST_WR_ISSUE;
    else         return ST_IDLE;
  endfunction

endpackage

// File: rtl/rf_access_master.sv
// Sequences read / write / read-then-write accesses to the 32x32 register file.
// Latency: response at acceptance+3 (read), +2 (write), +4 (read-then-write).
// Backpressure: one request in flight; response held until RSP_READY, REQ_READY low meanwhile.
//
// Ports:
//   CLK, RST (async, active-low)       clock and reset shared with the file
//   REQ_*                              request handshake and fields
//   RSP_*                              held response handshake, read data, error
//   RF_READ/RF_WRITE/RF_ADDR_*/RF_DATA_W  registered drive to the file
//   RF_DATA_R1/RF_DATA_R2              tri-stated read data from the file
module rf_access_master
  import rf_access_master_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_RD,
  input  logic                  REQ_WR,
  input  logic [ADDR_WIDTH-1:0] REQ_RS1,
  input  logic [ADDR_WIDTH-1:0] REQ_RS2,
  input  logic [ADDR_WIDTH-1:0] REQ_RDST,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA1,
  output logic [DATA_WIDTH-1:0] RSP_DATA2,
  output logic                  RSP_ERR,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  rfm_state_t            state;

  // Write half of a read-then-write, parked while the read completes.
  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_rdst;
  logic [DATA_WIDTH-1:0] lat_wdata;

  // Nothing is accepted while reset is held.
  assign REQ_READY = RST && (state == ST_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      lat_wr     <= 1'b0;
      lat_rdst   <= '0;
      lat_wdata  <= '0;
      RSP_VALID  <= 1'b0;
      RSP_DATA1  <= '0;
      RSP_DATA2  <= '0;
      RSP_ERR    <= 1'b0;
      RF_READ    <= 1'b0;
      RF_WRITE   <= 1'b0;
      RF_ADDR_R1 <= '0;
      RF_ADDR_R2 <= '0;
      RF_ADDR_W  <= '0;
      RF_DATA_W  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            lat_wr    <= REQ_WR;
            lat_rdst  <= REQ_RDST;
            lat_wdata <= REQ_WDATA;
            state     <= first_state(REQ_RD, REQ_WR);
            if (REQ_RD) begin
              // Read addresses become the latched copy of RS1/RS2.
              RF_READ    <= 1'b1;
              RF_ADDR_R1 <= REQ_RS1;
              RF_ADDR_R2 <= REQ_RS2;
            end else begin
              // No read in this request: response data reads as zero.
              RSP_DATA1 <= '0;
              RSP_DATA2 <= '0;
              RSP_ERR   <= 1'b0;
              if (REQ_WR) begin
                RF_WRITE  <= 1'b1;
                RF_ADDR_W <= REQ_RDST;
                RF_DATA_W <= REQ_WDATA;
              end
            end
          end
        end

        // The file latches its read word at the end of this cycle.
        ST_RD_ISSUE: begin
          state <= ST_RD_CAPTURE;
        end

        // Strobe stays high so the file keeps driving the bus while we sample.
        ST_RD_CAPTURE: begin
          RSP_DATA1 <= RF_DATA_R1;
          RSP_DATA2 <= RF_DATA_R2;
          RSP_ERR   <= $isunknown(RF_DATA_R1) || $isunknown(RF_DATA_R2);
          RF_READ   <= 1'b0;
          if (lat_wr) begin
            // Write lands after the read, so the read sees the old value.
            state     <= ST_WR_ISSUE;
            RF_WRITE  <= 1'b1;
            RF_ADDR_W <= lat_rdst;
            RF_DATA_W <= lat_wdata;
          end else begin
            state     <= ST_RESP;
            RSP_VALID <= 1'b1;
          end
        end

        ST_WR_ISSUE: begin
          RF_WRITE  <= 1'b0;
          state     <= ST_RESP;
          RSP_VALID <= 1'b1;
        end

        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          RF_READ  <= 1'b0;
          RF_WRITE <= 1'b0;
        end
      endcase
    end
  end

endmodule
